ahb_slave_if: RTL and testbench
===============================

# ahb_slave_if

AHB-Lite slave front end of the AHB-to-APB bridge. It samples AHB address phases, captures write data, and stalls the AHB bus with `hreadyout_o` while one request is handed over a valid/ready link to the downstream APB master FSM. It then returns read data and the OKAY or ERROR response to the AHB master. One transfer is outstanding at a time, with no posting or buffering beyond a single request register.

## Interface
- `ADDR_W`, 32, address width (AHB and request link)
- `DATA_W`, 32, data width; only full-word transfers are supported
- `clk`  in  1  single clock shared by AHB and APB sides
- `preset_n`  in  1  asynchronous, active-low reset
- `hsel_i`  in  1  slave select
- `haddr_i`  in  ADDR_W  transfer address
- `htrans_i`  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- `hwrite_i`  in  1  1 = write
- `hsize_i`  in  3  transfer size; only 3'b010 is legal
- `hwdata_i`  in  DATA_W  write data, valid in the data phase
- `hready_i`  in  1  bus-wide HREADY
- `hreadyout_o`  out  1  slave ready
- `hresp_o`  out  1  0 = OKAY, 1 = ERROR
- `hrdata_o`  out  DATA_W  read data
- `req_valid_o`  out  1  request valid toward the APB master
- `req_ready_i`  in  1  APB master accepts the request
- `req_addr_o`  out  ADDR_W  request address
- `req_write_o`  out  1  request direction
- `req_wdata_o`  out  DATA_W  write data; 0 for reads
- `rsp_valid_i`  in  1  APB transfer complete (PREADY seen in ACCESS)
- `rsp_rdata_i`  in  DATA_W  PRDATA
- `rsp_err_i`  in  1  PSLVERR

## Operation
- An address phase is accepted when `hsel_i & hready_i & htrans_i[1]`. On acceptance, `haddr_i` and `hwrite_i` are registered.
- IDLE or BUSY transfers, or unselected cycles, get a zero-wait OKAY with no state change.
- States are IDLE, DATA, REQ, WAIT, ERR1, ERR2.
- **IDLE:** `hreadyout_o` = 1, `hresp_o` = 0.
  - Legal accept goes to DATA.
  - Accept with `hsize_i` != 010 or `haddr_i[1:0]` != 0 goes to ERR1. No downstream request is issued.
- **DATA:** `hreadyout_o` = 0. Capture `hwdata_i` if the transfer is a write. Go to REQ.
- **REQ:** `req_valid_o` = 1 and `hreadyout_o` = 0.
  - `req_addr_o`, `req_write_o` and `req_wdata_o` stay stable while valid.
  - On `req_ready_i` = 1, go to WAIT.
- **WAIT:** `hreadyout_o` = 0. `rsp_valid_i` is sampled only in this state and ignored in all others.
  - `rsp_valid_i` with `rsp_err_i` = 0: register `rsp_rdata_i` into `hrdata_o`, then go to IDLE.
  - `rsp_valid_i` with `rsp_err_i` = 1: go to ERR1.
- **ERR1:** `hresp_o` = 1, `hreadyout_o` = 0. Go to ERR2.
- **ERR2:** `hresp_o` = 1, `hreadyout_o` = 1.
  - An address phase presented here is evaluated with the IDLE acceptance rules.
  - If accepted, go to DATA or ERR1; otherwise go to IDLE.
- `hrdata_o` holds its last value until the next successful read completes. Writes do not change it.

## Timing
- **Reset values:**
  - `hreadyout_o` = 1, `hresp_o` = 0, `hrdata_o` = 0, `req_valid_o` = 0.
  - `req_addr_o` = 0, `req_write_o` = 0, `req_wdata_o` = 0.
  - State = IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- **Latency:**
  - Address accepted in cycle T: `hreadyout_o` is 0 from T+1, and `req_valid_o` rises at T+2.
  - `rsp_valid_i` in cycle N gives `hreadyout_o` = 1 with data at N+1, or ERR1 at N+1.
- **Back-to-back:** the data-phase completion cycle (IDLE after WAIT, or ERR2) may accept the next address phase.
- **Reset mid-transfer:** all registers return to reset values immediately. `req_valid_o` deasserts asynchronously, and the pending request is dropped.
- **`req_ready_i` high outside REQ:** ignored.

## Structure
- Shared package `bridge_pkg` holds:
  - HTRANS encodings and the HRESP constants.
  - `ahb_state_t` enum.
  - Packed struct `bridge_req_t` {addr, write, wdata}, also used by the APB master.
- No sub-module; a single FSM plus datapath registers.
- The APB master sits directly downstream and consumes the `req_*` and `rsp_*` link.

## Test plan
- **Read, no waits:**
  - Stimulus: NONSEQ read 0x0000_A000 at T; `req_ready_i` = 1 at T+2; `rsp_valid_i` with `rsp_rdata_i` = 0xDEAD_BEEF at T+4.
  - Response: `hreadyout_o` low T+1..T+4; high at T+5 with `hrdata_o` = 0xDEAD_BEEF.
- **Write with backpressure:**
  - Stimulus: NONSEQ write 0x0000_A004, `hwdata_i` = 0x1234_5678 at T+1; `req_ready_i` held 0 for 3 cycles.
  - Response: `req_valid_o` stays high with stable addr/data until ready; `req_wdata_o` = 0x1234_5678.
- **PSLVERR:**
  - Stimulus: `rsp_err_i` = 1 with `rsp_valid_i`.
  - Response: two-cycle ERROR: `hresp_o` = 1 with `hreadyout_o` 0 then 1.
- **Illegal size/alignment:**
  - Stimulus: `hsize_i` = 000, or `haddr_i` = 0x...A002.
  - Response: two-cycle ERROR; `req_valid_o` never asserts.
- **Back-to-back:**
  - Stimulus: second NONSEQ presented in the completion cycle of the first transfer.
  - Response: the second transfer is accepted with no idle gap; IDLE or BUSY transfers return a zero-wait OKAY.
- **Reset mid-transfer:**
  - Stimulus: assert `preset_n` = 0 while in REQ.
  - Response: `req_valid_o` = 0 immediately; all outputs at reset values; normal operation after release.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: AHB encodings, the AHB-side
// FSM state type and the request record handed to the APB master.
package bridge_pkg;

    localparam int BRIDGE_ADDR_W = 32;
    localparam int BRIDGE_DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } ahb_state_t;

    typedef struct packed {
        logic [BRIDGE_ADDR_W-1:0] addr;
        logic                     write;
        logic [BRIDGE_DATA_W-1:0] wdata;
    } bridge_req_t;

    // Only word-sized, word-aligned transfers can be forwarded to APB.
    function automatic logic legal_xfer(input logic [2:0] size, input logic [1:0] addr_lo);
        legal_xfer = (size == HSIZE_WORD) && (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: holds the bus with hreadyout while one request
// travels to the APB master, then returns read data and OKAY/ERROR.
module ahb_slave_if
    import bridge_pkg::*;
#(
    parameter int ADDR_W = BRIDGE_ADDR_W,
    parameter int DATA_W = BRIDGE_DATA_W
) (
    input  logic              clk,
    input  logic              preset_n,
    input  logic              hsel_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic [1:0]        htrans_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [DATA_W-1:0] hwdata_i,
    input  logic              hready_i,
    output logic              hreadyout_o,
    output logic              hresp_o,
    output logic [DATA_W-1:0] hrdata_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic              req_write_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_rdata_i,
    input  logic              rsp_err_i
);

    ahb_state_t        state_r;
    ahb_state_t        state_nxt_s;
    bridge_req_t       req_r;
    logic [DATA_W-1:0] hrdata_r;
    logic              accept_s;
    logic              legal_s;
    logic              addr_phase_s;
    logic              hreadyout_s;
    logic              hresp_s;
    logic              req_valid_s;

    assign accept_s     = hsel_i & hready_i &
                          ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));
    assign legal_s      = legal_xfer(hsize_i, haddr_i[1:0]);
    // ERR2 is a completion cycle, so it may take a new address phase like IDLE.
    assign addr_phase_s = (state_r == ST_IDLE) || (state_r == ST_ERR2);

    // State register.
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (accept_s) begin
                    state_nxt_s = legal_s ? ST_DATA : ST_ERR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: state_nxt_s = ST_REQ;
            ST_REQ: begin
                if (req_ready_i) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rsp_valid_i) begin
                    state_nxt_s = rsp_err_i ? ST_ERR1 : ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus handshake outputs decoded from state alone.
    always_comb begin
        hreadyout_s = 1'b1;
        hresp_s     = HRESP_OKAY;
        req_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hreadyout_s = 1'b1;
                hresp_s     = HRESP_OKAY;
            end
            ST_DATA, ST_WAIT: begin
                hreadyout_s = 1'b0;
            end
            ST_REQ: begin
                hreadyout_s = 1'b0;
                req_valid_s = 1'b1;
            end
            ST_ERR1: begin
                hreadyout_s = 1'b0;
                hresp_s     = HRESP_ERROR;
            end
            ST_ERR2: begin
                hreadyout_s = 1'b1;
                hresp_s     = HRESP_ERROR;
            end
            default: begin
                hreadyout_s = 1'b1;
                hresp_s     = HRESP_OKAY;
            end
        endcase
    end

    // Request and read-data registers; wdata is zeroed for reads.
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            req_r    <= '0;
            hrdata_r <= '0;
        end else begin
            if (addr_phase_s && accept_s) begin
                req_r.addr  <= haddr_i;
                req_r.write <= hwrite_i;
            end
            if (state_r == ST_DATA) begin
                req_r.wdata <= req_r.write ? hwdata_i : '0;
            end
            if ((state_r == ST_WAIT) && rsp_valid_i && !rsp_err_i && !req_r.write) begin
                hrdata_r <= rsp_rdata_i;
            end
        end
    end

    assign hreadyout_o = hreadyout_s;
    assign hresp_o     = hresp_s;
    assign req_valid_o = req_valid_s;
    assign hrdata_o    = hrdata_r;
    assign req_addr_o  = req_r.addr;
    assign req_write_o = req_r.write;
    assign req_wdata_o = req_r.wdata;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: inputs change and outputs are sampled 1 ns
// after each rising edge, one task per scenario.
module tb_ahb_slave_if;

    logic        clk;
    logic        preset_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ahb_slave_if dut (
        .clk        (clk),
        .preset_n   (preset_n),
        .hsel_i     (hsel),
        .haddr_i    (haddr),
        .htrans_i   (htrans),
        .hwrite_i   (hwrite),
        .hsize_i    (hsize),
        .hwdata_i   (hwdata),
        .hready_i   (hready),
        .hreadyout_o(hreadyout),
        .hresp_o    (hresp),
        .hrdata_o   (hrdata),
        .req_valid_o(req_valid),
        .req_ready_i(req_ready),
        .req_addr_o (req_addr),
        .req_write_o(req_write),
        .req_wdata_o(req_wdata),
        .rsp_valid_i(rsp_valid),
        .rsp_rdata_i(rsp_rdata),
        .rsp_err_i  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'b010;
    endtask

    task automatic present(input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic test_reset;
        preset_n  = 1'b0;
        drive_idle();
        hwdata    = 32'h0;
        hready    = 1'b1;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        tick();
        tick();
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL rst_hreadyout got %b exp 1", hreadyout); else pass_cnt++;
        total_cnt++; if (hresp !== 1'b0) $display("FAIL rst_hresp got %b exp 0", hresp); else pass_cnt++;
        total_cnt++; if (hrdata !== 32'h0) $display("FAIL rst_hrdata got %h exp 0", hrdata); else pass_cnt++;
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL rst_req_valid got %b exp 0", req_valid); else pass_cnt++;
        total_cnt++; if (req_addr !== 32'h0) $display("FAIL rst_req_addr got %h exp 0", req_addr); else pass_cnt++;
        total_cnt++; if (req_write !== 1'b0) $display("FAIL rst_req_write got %b exp 0", req_write); else pass_cnt++;
        total_cnt++; if (req_wdata !== 32'h0) $display("FAIL rst_req_wdata got %h exp 0", req_wdata); else pass_cnt++;
        preset_n = 1'b1;
        tick();
    endtask

    task automatic test_read;
        present(32'h0000_A000, 1'b0, 3'b010);                        // T
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL rd_T_ready got %b exp 1", hreadyout); else pass_cnt++;
        tick();                                                      // T+1
        drive_idle();
        total_cnt++; if (hreadyout !== 1'b0) $display("FAIL rd_T1_ready got %b exp 0", hreadyout); else pass_cnt++;
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL rd_T1_valid got %b exp 0", req_valid); else pass_cnt++;
        tick();                                                      // T+2
        total_cnt++; if (req_valid !== 1'b1) $display("FAIL rd_T2_valid got %b exp 1", req_valid); else pass_cnt++;
        total_cnt++; if (req_addr !== 32'h0000_A000) $display("FAIL rd_addr got %h exp 0000a000", req_addr); else pass_cnt++;
        total_cnt++; if (req_write !== 1'b0) $display("FAIL rd_write got %b exp 0", req_write); else pass_cnt++;
        total_cnt++; if (req_wdata !== 32'h0) $display("FAIL rd_wdata got %h exp 0", req_wdata); else pass_cnt++;
        req_ready = 1'b1;
        tick();                                                      // T+3
        req_ready = 1'b0;
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL rd_T3_valid got %b exp 0", req_valid); else pass_cnt++;
        total_cnt++; if (hreadyout !== 1'b0) $display("FAIL rd_T3_ready got %b exp 0", hreadyout); else pass_cnt++;
        tick();                                                      // T+4
        total_cnt++; if (hreadyout !== 1'b0) $display("FAIL rd_T4_ready got %b exp 0", hreadyout); else pass_cnt++;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hDEAD_BEEF;
        tick();                                                      // T+5
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL rd_T5_ready got %b exp 1", hreadyout); else pass_cnt++;
        total_cnt++; if (hresp !== 1'b0) $display("FAIL rd_T5_resp got %b exp 0", hresp); else pass_cnt++;
        total_cnt++; if (hrdata !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h exp deadbeef", hrdata); else pass_cnt++;
    endtask

    task automatic test_write_backpressure;
        present(32'h0000_A004, 1'b1, 3'b010);                        // T
        tick();                                                      // T+1
        drive_idle();
        hwdata = 32'h1234_5678;
        total_cnt++; if (hreadyout !== 1'b0) $display("FAIL wr_T1_ready got %b exp 0", hreadyout); else pass_cnt++;
        tick();                                                      // T+2
        hwdata = 32'hFFFF_0000;
        // a response strobe outside WAIT must be ignored
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (req_valid !== 1'b1) $display("FAIL wr_bp_valid[%0d] got %b exp 1", i, req_valid); else pass_cnt++;
            total_cnt++; if (req_addr !== 32'h0000_A004) $display("FAIL wr_bp_addr[%0d] got %h exp 0000a004", i, req_addr); else pass_cnt++;
            total_cnt++; if (req_write !== 1'b1) $display("FAIL wr_bp_write[%0d] got %b exp 1", i, req_write); else pass_cnt++;
            total_cnt++; if (req_wdata !== 32'h1234_5678) $display("FAIL wr_bp_wdata[%0d] got %h exp 12345678", i, req_wdata); else pass_cnt++;
            tick();
        end
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        total_cnt++; if (req_valid !== 1'b1) $display("FAIL wr_pre_ready_valid got %b exp 1", req_valid); else pass_cnt++;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL wr_after_ready_valid got %b exp 0", req_valid); else pass_cnt++;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h5555_5555;
        tick();
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL wr_done_ready got %b exp 1", hreadyout); else pass_cnt++;
        total_cnt++; if (hresp !== 1'b0) $display("FAIL wr_done_resp got %b exp 0", hresp); else pass_cnt++;
        total_cnt++; if (hrdata !== 32'hDEAD_BEEF) $display("FAIL wr_keeps_hrdata got %h exp deadbeef", hrdata); else pass_cnt++;
    endtask

    task automatic test_pslverr;
        present(32'h0000_A008, 1'b0, 3'b010);                        // T
        tick();
        drive_idle();                                                // T+1
        tick();
        req_ready = 1'b1;                                            // T+2
        tick();
        req_ready = 1'b0;                                            // T+3 WAIT
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        rsp_rdata = 32'hAAAA_AAAA;
        tick();                                                      // T+4 ERR1
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        total_cnt++; if (hresp !== 1'b1) $display("FAIL perr_e1_resp got %b exp 1", hresp); else pass_cnt++;
        total_cnt++; if (hreadyout !== 1'b0) $display("FAIL perr_e1_ready got %b exp 0", hreadyout); else pass_cnt++;
        tick();                                                      // T+5 ERR2
        total_cnt++; if (hresp !== 1'b1) $display("FAIL perr_e2_resp got %b exp 1", hresp); else pass_cnt++;
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL perr_e2_ready got %b exp 1", hreadyout); else pass_cnt++;
        tick();                                                      // T+6 IDLE
        total_cnt++; if (hresp !== 1'b0) $display("FAIL perr_idle_resp got %b exp 0", hresp); else pass_cnt++;
        total_cnt++; if (hrdata !== 32'hDEAD_BEEF) $display("FAIL perr_hrdata got %h exp deadbeef", hrdata); else pass_cnt++;
    endtask

    task automatic test_illegal;
        logic [31:0] addrs [2];
        logic [2:0]  sizes [2];
        addrs[0] = 32'h0000_A00C; sizes[0] = 3'b000;
        addrs[1] = 32'h0000_A002; sizes[1] = 3'b010;
        for (int k = 0; k < 2; k++) begin
            present(addrs[k], 1'b0, sizes[k]);
            tick();                                                  // ERR1
            drive_idle();
            total_cnt++; if (hresp !== 1'b1) $display("FAIL ill%0d_e1_resp got %b exp 1", k, hresp); else pass_cnt++;
            total_cnt++; if (hreadyout !== 1'b0) $display("FAIL ill%0d_e1_ready got %b exp 0", k, hreadyout); else pass_cnt++;
            total_cnt++; if (req_valid !== 1'b0) $display("FAIL ill%0d_e1_valid got %b exp 0", k, req_valid); else pass_cnt++;
            tick();                                                  // ERR2
            total_cnt++; if (hresp !== 1'b1) $display("FAIL ill%0d_e2_resp got %b exp 1", k, hresp); else pass_cnt++;
            total_cnt++; if (hreadyout !== 1'b1) $display("FAIL ill%0d_e2_ready got %b exp 1", k, hreadyout); else pass_cnt++;
            total_cnt++; if (req_valid !== 1'b0) $display("FAIL ill%0d_e2_valid got %b exp 0", k, req_valid); else pass_cnt++;
            tick();                                                  // IDLE
            total_cnt++; if (req_valid !== 1'b0) $display("FAIL ill%0d_idle_valid got %b exp 0", k, req_valid); else pass_cnt++;
            total_cnt++; if (hresp !== 1'b0) $display("FAIL ill%0d_idle_resp got %b exp 0", k, hresp); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        present(32'h0000_A010, 1'b0, 3'b010);                        // T
        tick();
        drive_idle();
        tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;                                            // WAIT
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1111_2222;
        tick();                                                      // completion
        rsp_valid = 1'b0;
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL b2b_done_ready got %b exp 1", hreadyout); else pass_cnt++;
        total_cnt++; if (hrdata !== 32'h1111_2222) $display("FAIL b2b_rd_data got %h exp 11112222", hrdata); else pass_cnt++;
        present(32'h0000_A014, 1'b1, 3'b010);
        tick();                                                      // data phase of 2nd
        drive_idle();
        hwdata = 32'hCAFE_0000;
        total_cnt++; if (hreadyout !== 1'b0) $display("FAIL b2b_accept_ready got %b exp 0", hreadyout); else pass_cnt++;
        tick();
        total_cnt++; if (req_valid !== 1'b1) $display("FAIL b2b_req_valid got %b exp 1", req_valid); else pass_cnt++;
        total_cnt++; if (req_addr !== 32'h0000_A014) $display("FAIL b2b_req_addr got %h exp 0000a014", req_addr); else pass_cnt++;
        total_cnt++; if (req_write !== 1'b1) $display("FAIL b2b_req_write got %b exp 1", req_write); else pass_cnt++;
        total_cnt++; if (req_wdata !== 32'hCAFE_0000) $display("FAIL b2b_req_wdata got %h exp cafe0000", req_wdata); else pass_cnt++;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h9999_9999;
        tick();                                                      // completion of write
        rsp_valid = 1'b0;
        total_cnt++; if (hrdata !== 32'h1111_2222) $display("FAIL b2b_wr_hrdata got %h exp 11112222", hrdata); else pass_cnt++;
        present(32'h0000_A01C, 1'b0, 3'b000);
        tick();                                                      // ERR1
        drive_idle();
        tick();                                                      // ERR2: next address here
        present(32'h0000_A018, 1'b0, 3'b010);
        tick();
        drive_idle();
        total_cnt++; if (hreadyout !== 1'b0) $display("FAIL b2b_err2_accept_ready got %b exp 0", hreadyout); else pass_cnt++;
        total_cnt++; if (hresp !== 1'b0) $display("FAIL b2b_err2_accept_resp got %b exp 0", hresp); else pass_cnt++;
        tick();
        total_cnt++; if (req_addr !== 32'h0000_A018) $display("FAIL b2b_err2_addr got %h exp 0000a018", req_addr); else pass_cnt++;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h0F0F_0F0F;
        tick();
        rsp_valid = 1'b0;
        total_cnt++; if (hrdata !== 32'h0F0F_0F0F) $display("FAIL b2b_err2_data got %h exp 0f0f0f0f", hrdata); else pass_cnt++;
        // zero-wait OKAY for BUSY, IDLE and unselected NONSEQ; stray req_ready ignored
        req_ready = 1'b1;
        hsel = 1'b1; htrans = 2'b01; haddr = 32'h0000_A020;
        tick();
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL busy_ready got %b exp 1", hreadyout); else pass_cnt++;
        htrans = 2'b00;
        tick();
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL idle_ready got %b exp 1", hreadyout); else pass_cnt++;
        hsel = 1'b0; htrans = 2'b10;
        tick();
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL nosel_ready got %b exp 1", hreadyout); else pass_cnt++;
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL nosel_valid got %b exp 0", req_valid); else pass_cnt++;
        drive_idle();
        req_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        present(32'h0000_A020, 1'b1, 3'b010);
        tick();
        drive_idle();
        hwdata = 32'h7777_7777;
        tick();                                                      // REQ
        total_cnt++; if (req_valid !== 1'b1) $display("FAIL rm_in_req got %b exp 1", req_valid); else pass_cnt++;
        #2;
        preset_n = 1'b0;
        #1;
        total_cnt++; if (req_valid !== 1'b0) $display("FAIL rm_valid got %b exp 0", req_valid); else pass_cnt++;
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL rm_ready got %b exp 1", hreadyout); else pass_cnt++;
        total_cnt++; if (req_addr !== 32'h0) $display("FAIL rm_addr got %h exp 0", req_addr); else pass_cnt++;
        total_cnt++; if (req_wdata !== 32'h0) $display("FAIL rm_wdata got %h exp 0", req_wdata); else pass_cnt++;
        total_cnt++; if (hrdata !== 32'h0) $display("FAIL rm_hrdata got %h exp 0", hrdata); else pass_cnt++;
        tick();
        preset_n = 1'b1;
        tick();
        present(32'h0000_A024, 1'b0, 3'b010);
        tick();
        drive_idle();
        tick();
        total_cnt++; if (req_addr !== 32'h0000_A024) $display("FAIL rm_post_addr got %h exp 0000a024", req_addr); else pass_cnt++;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h0BAD_F00D;
        tick();
        rsp_valid = 1'b0;
        total_cnt++; if (hrdata !== 32'h0BAD_F00D) $display("FAIL rm_post_data got %h exp 0badf00d", hrdata); else pass_cnt++;
        total_cnt++; if (hreadyout !== 1'b1) $display("FAIL rm_post_ready got %b exp 1", hreadyout); else pass_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_read();
        test_write_backpressure();
        test_pslverr();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
